// File: rtl/itl_rx_wr_ctrl.sv
// itl_rx_wr_ctrl: fills the RX deinterleaver memory with one PB of symbol pairs,
// then replays the address sweep so the memory emits original and deinterleaved data.
`default_nettype none

module itl_rx_wr_ctrl #(
   parameter int D_WIDTH   = 2,
   parameter int A_WIDTH   = 12,
   parameter int OFS_PB16  = 0,
   parameter int OFS_PB136 = 64,
   parameter int OFS_PB520 = 608
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [1:0]         pb_size,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [D_WIDTH-1:0] s_data,
   input  logic               s_last,
   output logic [D_WIDTH-1:0] wdata,
   output logic [A_WIDTH-1:0] waddr,
   output logic               wen,
   output logic               din_vld,
   output logic [A_WIDTH-1:0] pb_offset,
   output logic               busy,
   output logic               done,
   output logic               err
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_GAP   = 2'd2,
      ST_READ  = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic [A_WIDTH-1:0]   cnt_q, cnt_d;
   logic [1:0]           size_q, size_d;
   logic                 s_ready_q, s_ready_d;
   logic                 wen_q, wen_d;
   logic [D_WIDTH-1:0]   wdata_q, wdata_d;
   logic [A_WIDTH-1:0]   waddr_q, waddr_d;
   logic                 din_vld_q, din_vld_d;
   logic [A_WIDTH-1:0]   pb_offset_q, pb_offset_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;
   logic [A_WIDTH-1:0]   last_idx;
   logic                 accept;

   function automatic logic [A_WIDTH-1:0] ofs_of(input logic [1:0] sz);
      case (sz)
         2'd0:    return A_WIDTH'(OFS_PB16);
         2'd1:    return A_WIDTH'(OFS_PB136);
         default: return A_WIDTH'(OFS_PB520);
      endcase
   endfunction

   always_comb begin
      case (size_q)
         2'd0:    last_idx = A_WIDTH'(63);
         2'd1:    last_idx = A_WIDTH'(543);
         default: last_idx = A_WIDTH'(2079);
      endcase
   end

   assign accept = (state_q == ST_WRITE) && s_valid && s_ready_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      size_d      = size_q;
      s_ready_d   = 1'b0;
      wen_d       = 1'b0;
      wdata_d     = wdata_q;
      waddr_d     = waddr_q;
      din_vld_d   = 1'b0;
      pb_offset_d = pb_offset_q;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      err_d       = err_q;

      case (state_q)
         ST_IDLE: begin
            // busy_q is still high during the done cycle; a start there is ignored
            if (start && !busy_q) begin
               if (pb_size == 2'd3) begin
                  err_d = 1'b1;
               end else begin
                  size_d      = pb_size;
                  pb_offset_d = ofs_of(pb_size);
                  err_d       = 1'b0;
                  cnt_d       = '0;
                  s_ready_d   = 1'b1;
                  busy_d      = 1'b1;
                  state_d     = ST_WRITE;
               end
            end
         end
         ST_WRITE: begin
            busy_d    = 1'b1;
            s_ready_d = 1'b1;
            if (accept) begin
               if (cnt_q == last_idx) begin
                  wen_d     = 1'b1;
                  wdata_d   = s_data;
                  waddr_d   = cnt_q;
                  s_ready_d = 1'b0;
                  state_d   = ST_GAP;
                  if (!s_last) err_d = 1'b1;
               end else if (s_last) begin
                  err_d     = 1'b1;
                  s_ready_d = 1'b0;
                  busy_d    = 1'b0;
                  state_d   = ST_IDLE;
               end else begin
                  wen_d   = 1'b1;
                  wdata_d = s_data;
                  waddr_d = cnt_q;
                  cnt_d   = cnt_q + A_WIDTH'(1);
               end
            end
         end
         ST_GAP: begin
            busy_d  = 1'b1;
            cnt_d   = '0;
            state_d = ST_READ;
         end
         ST_READ: begin
            busy_d    = 1'b1;
            din_vld_d = 1'b1;
            waddr_d   = cnt_q;
            if (cnt_q == last_idx) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + A_WIDTH'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         size_q      <= '0;
         s_ready_q   <= 1'b0;
         wen_q       <= 1'b0;
         wdata_q     <= '0;
         waddr_q     <= '0;
         din_vld_q   <= 1'b0;
         pb_offset_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         size_q      <= size_d;
         s_ready_q   <= s_ready_d;
         wen_q       <= wen_d;
         wdata_q     <= wdata_d;
         waddr_q     <= waddr_d;
         din_vld_q   <= din_vld_d;
         pb_offset_q <= pb_offset_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign s_ready   = s_ready_q;
   assign wen       = wen_q;
   assign wdata     = wdata_q;
   assign waddr     = waddr_q;
   assign din_vld   = din_vld_q;
   assign pb_offset = pb_offset_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_itl_rx_wr_ctrl.sv
// tb_itl_rx_wr_ctrl: randomized PB traffic checked against a queue-based model
// of the expected write stream and read sweep.
`default_nettype none

module tb_itl_rx_wr_ctrl;

   localparam int DW = 2;
   localparam int AW = 12;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [1:0]    pb_size = 2'd0;
   logic          s_valid = 1'b0;
   logic [DW-1:0] s_data = '0;
   logic          s_last = 1'b0;
   logic          s_ready, wen, din_vld, busy, done, err;
   logic [DW-1:0] wdata;
   logic [AW-1:0] waddr, pb_offset;

   itl_rx_wr_ctrl #(.D_WIDTH(DW), .A_WIDTH(AW)) dut (
      .clk(clk), .rst(rst), .start(start), .pb_size(pb_size),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .wdata(wdata), .waddr(waddr), .wen(wen), .din_vld(din_vld),
      .pb_offset(pb_offset), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct { int cyc; int addr; int data; } ev_t;

   ev_t wq[$];
   ev_t rq[$];
   int  exp_w[$];
   int  cyc = 0;
   int  done_cnt = 0, ofs_bad = 0, ovl_bad = 0;
   int  exp_ofs = 0;
   int  checks = 0, errors = 0;

   function automatic int n_of(input int s);
      case (s)
         0:       return 64;
         1:       return 544;
         default: return 2080;
      endcase
   endfunction

   function automatic int ofs_of(input int s);
      case (s)
         0:       return 0;
         1:       return 64;
         default: return 608;
      endcase
   endfunction

   always @(posedge clk) cyc++;

   // Observation of the memory-side interface, sampled mid-cycle
   always @(negedge clk) begin
      ev_t e;
      if (wen === 1'b1) begin
         e.cyc = cyc; e.addr = int'(waddr); e.data = int'(wdata);
         wq.push_back(e);
      end
      if (din_vld === 1'b1) begin
         e.cyc = cyc; e.addr = int'(waddr); e.data = int'(done);
         rq.push_back(e);
      end
      if (done === 1'b1) done_cnt++;
      if (busy === 1'b1 && int'(pb_offset) != exp_ofs) ofs_bad++;
      if ((wen && din_vld) || (s_ready && !busy) || (s_ready && din_vld)) ovl_bad++;
   end

   task automatic clear_mon();
      @(posedge clk); #1;
      wq.delete(); rq.delete(); exp_w.delete();
      done_cnt = 0; ofs_bad = 0; ovl_bad = 0;
   endtask

   // mode 0: always valid, 1: valid toggles every cycle, 2: random valid
   task automatic drive_pb(input int size, input int mode, input int last_at,
                           input bit mid_start, input bit wait_end, output bit timeout);
      int n, idx, guard;
      bit ph, v, aborted;
      logic [DW-1:0] d;
      n = n_of(size); idx = 0; guard = 0; ph = 1'b1; aborted = 1'b0;
      clear_mon();
      exp_ofs = ofs_of(size);
      @(negedge clk); start = 1'b1; pb_size = 2'(size);
      @(negedge clk); start = 1'b0;
      while (idx < n && !aborted && guard < 20000) begin
         @(negedge clk);
         guard++;
         start   = mid_start && (idx == 20);
         pb_size = start ? 2'd2 : 2'(size);
         v  = (mode == 0) ? 1'b1 : (mode == 1) ? ph : 1'($urandom_range(0, 1));
         ph = ~ph;
         d  = DW'($urandom);
         s_valid = v; s_data = d; s_last = (idx == last_at);
         if (v && s_ready) begin
            if (idx == last_at && last_at < n - 1) aborted = 1'b1;
            else exp_w.push_back(int'(d));
            idx++;
         end
      end
      @(negedge clk);
      s_valid = 1'b0; s_last = 1'b0; start = 1'b0; pb_size = 2'(size);
      timeout = (guard >= 20000);
      if (wait_end) begin
         guard = 0;
         while (busy && guard < 6000) begin
            @(negedge clk);
            guard++;
         end
         if (busy) timeout = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({s_ready, wen, din_vld, busy, done, err} !== 6'b0) begin
         errors++; $display("FAIL reset_ctrl got=%b want=000000", {s_ready, wen, din_vld, busy, done, err});
      end
      checks++;
      if (waddr !== '0 || wdata !== '0 || pb_offset !== '0) begin
         errors++; $display("FAIL reset_data waddr=%0d wdata=%0d ofs=%0d want 0", waddr, wdata, pb_offset);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || s_ready !== 1'b0) begin
         errors++; $display("FAIL idle_after_reset busy=%b s_ready=%b want 0", busy, s_ready);
      end
   endtask

   task automatic test_complete_pb(input int size, input int mode, input bit mid_start);
      bit to;
      int n, bad, last;
      n = n_of(size);
      drive_pb(size, mode, n - 1, mid_start, 1'b1, to);
      checks++;
      if (to) begin errors++; $display("FAIL pb%0d_timeout busy=%b want 0", size, busy); end
      checks++;
      if (wq.size() != n) begin
         errors++; $display("FAIL pb%0d_write_count got=%0d want=%0d", size, wq.size(), n);
      end
      bad = 0;
      for (int i = 0; i < wq.size() && i < exp_w.size(); i++) begin
         if (wq[i].addr != i || wq[i].data != exp_w[i]) bad++;
         if (mode < 2 && i > 0 && wq[i].cyc - wq[i-1].cyc != mode + 1) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL pb%0d_write_seq bad=%0d want=0", size, bad); end
      checks++;
      if (rq.size() != n) begin
         errors++; $display("FAIL pb%0d_read_count got=%0d want=%0d", size, rq.size(), n);
      end
      bad = 0;
      for (int i = 0; i < rq.size(); i++) begin
         if (rq[i].addr != i || rq[i].cyc != rq[0].cyc + i) bad++;
         if (rq[i].data != ((i == n - 1) ? 1 : 0)) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL pb%0d_read_seq bad=%0d want=0", size, bad); end
      if (wq.size() > 0 && rq.size() > 0) begin
         last = wq[wq.size()-1].cyc;
         checks++;
         if (rq[0].cyc != last + 2) begin
            errors++; $display("FAIL pb%0d_gap first_read=%0d want=%0d", size, rq[0].cyc, last + 2);
         end
      end
      checks++;
      if (done_cnt != 1 || err !== 1'b0) begin
         errors++; $display("FAIL pb%0d_done_err done_cnt=%0d err=%b want 1/0", size, done_cnt, err);
      end
      checks++;
      if (ofs_bad != 0 || ovl_bad != 0) begin
         errors++; $display("FAIL pb%0d_offset_overlap ofs_bad=%0d ovl_bad=%0d want 0/0", size, ofs_bad, ovl_bad);
      end
   endtask

   task automatic test_early_last();
      bit to;
      int bad;
      drive_pb(1, 2, 100, 1'b0, 1'b1, to);
      checks++;
      if (to) begin errors++; $display("FAIL abort_timeout busy=%b want 0", busy); end
      checks++;
      if (err !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b0) begin
         errors++; $display("FAIL abort_state err=%b busy=%b s_ready=%b want 1/0/0", err, busy, s_ready);
      end
      bad = (wq.size() != 100) ? 1 : 0;
      for (int i = 0; i < wq.size() && i < exp_w.size(); i++)
         if (wq[i].addr != i || wq[i].data != exp_w[i]) bad++;
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL abort_writes count=%0d bad=%0d want 100/0", wq.size(), bad);
      end
      repeat (5) @(negedge clk);
      checks++;
      if (rq.size() != 0 || done_cnt != 0 || err !== 1'b1) begin
         errors++; $display("FAIL abort_no_read reads=%0d done=%0d err=%b want 0/0/1", rq.size(), done_cnt, err);
      end
      drive_pb(0, 0, 63, 1'b0, 1'b1, to);
      checks++;
      if (to || err !== 1'b0 || done_cnt != 1 || wq.size() != 64) begin
         errors++; $display("FAIL err_clear err=%b done=%0d writes=%0d want 0/1/64", err, done_cnt, wq.size());
      end
   endtask

   task automatic test_reserved();
      int bad;
      clear_mon();
      @(negedge clk); start = 1'b1; pb_size = 2'd3;
      @(negedge clk); start = 1'b0; pb_size = 2'd0;
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         if (busy !== 1'b0 || s_ready !== 1'b0) bad++;
         @(negedge clk);
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL reserved_idle bad=%0d want=0", bad); end
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL reserved_err got=%b want=1", err); end
   endtask

   task automatic test_rst_read();
      bit to;
      int guard;
      drive_pb(1, 0, 543, 1'b0, 1'b0, to);
      guard = 0;
      while (!(din_vld === 1'b1 && waddr == 12'd300) && guard < 3000) begin
         @(negedge clk);
         guard++;
      end
      checks++;
      if (guard >= 3000 || to) begin
         errors++; $display("FAIL rst_read_reach waddr=%0d din_vld=%b want 300/1", waddr, din_vld);
      end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({s_ready, wen, din_vld, busy, done, err} !== 6'b0 || waddr !== '0 ||
          wdata !== '0 || pb_offset !== '0) begin
         errors++;
         $display("FAIL rst_read_outputs ctrl=%b waddr=%0d wdata=%0d ofs=%0d want all 0",
                  {s_ready, wen, din_vld, busy, done, err}, waddr, wdata, pb_offset);
      end
      rst = 1'b0;
      repeat (600) @(negedge clk);
      checks++;
      if (done_cnt != 0 || busy !== 1'b0) begin
         errors++; $display("FAIL rst_read_no_done done=%0d busy=%b want 0/0", done_cnt, busy);
      end
   endtask

   initial begin
      test_reset();
      test_complete_pb(0, 0, 1'b0);
      test_complete_pb(2, 1, 1'b0);
      test_complete_pb(1, 2, 1'b0);
      test_early_last();
      test_reserved();
      test_rst_read();
      test_complete_pb(0, 2, 1'b1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
